string_receiver: RTL

STRING_RECEIVER -- requirements
Module: string_receiver

---
 rtl/string_receiver.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/string_receiver.sv
// ---------------------------------------------------------------------------
// string_receiver
//
// Collects bytes from a UART receiver into a line buffer until a terminator
// byte arrives, then holds the completed line for a consumer to read out by
// address. The consumer releases the line with a single-cycle acknowledge,
// after which collection of the next line begins.
//
// Parameters
//   DEPTH  line buffer size in bytes (power of 2, 4..256)
//   TERM   terminator byte value (never stored)
//
// Ports
//   i_Clk         sole clock, rising edge
//   i_Rst         asynchronous active-low reset
//   i_rx_data     byte from the UART receiver, valid while i_rx_end is high
//   i_rx_end      byte-complete strobe (level, may stay high several cycles)
//   i_rd_addr     consumer read address into the line buffer
//   i_line_ack    consumer releases the current line (single-cycle pulse)
//   o_rd_data     registered buffer byte at i_rd_addr (8'h00 past the line)
//   o_line_valid  a complete line is held and readable
//   o_line_len    number of bytes stored, terminator excluded
//   o_busy        collecting and at least one byte stored
//   o_overflow    sticky: byte dropped because the buffer was full
//   o_overrun     sticky: byte dropped because a completed line was unacked
// ---------------------------------------------------------------------------
module string_receiver #(
  parameter int         DEPTH = 32,
  parameter logic [7:0] TERM  = 8'h00
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_end,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
  input  logic                       i_line_ack,
  output logic [7:0]                 o_rd_data,
  output logic                       o_line_valid,
  output logic [$clog2(DEPTH):0]     o_line_len,
  output logic                       o_busy,
  output logic                       o_overflow,
  output logic                       o_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    COLLECT    = 1'b0,
    LINE_READY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic            r_rx_end_d;
  logic            r_armed;
  logic [LW-1:0]   r_len;
  logic            r_overflow;
  logic            r_overrun;
  logic [7:0]      r_rd_data;
  logic [7:0]      r_buf [DEPTH];

  logic            w_accept;
  logic            w_is_term;
  logic            w_full;
  logic            w_store;
  logic            w_overflow_set;
  logic            w_overrun_set;
  logic            w_clear;

  // A byte is taken only on the rising edge of the strobe. r_armed stays low
  // after reset until the strobe has been seen low once, so a strobe that was
  // already high when reset released cannot masquerade as a fresh edge.
  assign w_accept  = i_rx_end & ~r_rx_end_d & r_armed;
  assign w_is_term = (i_rx_data == TERM);
  assign w_full    = (r_len == LW'(DEPTH));

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_rx_end_d <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_rx_end_d <= i_rx_end;
      r_armed    <= r_armed | ~i_rx_end;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state plus one-cycle action strobes for the datapath registers.
  always_comb begin
    w_next_state   = r_state;
    w_store        = 1'b0;
    w_overflow_set = 1'b0;
    w_overrun_set  = 1'b0;
    w_clear        = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_accept) begin
          if (!w_is_term) begin
            if (w_full) begin
              w_overflow_set = 1'b1;
            end else begin
              w_store = 1'b1;
            end
          end else if (r_len != '0) begin
            w_next_state = LINE_READY;
          end
        end
      end
      LINE_READY: begin
        if (w_accept) begin
          w_overrun_set = 1'b1;
        end
        if (i_line_ack) begin
          w_clear      = 1'b1;
          w_next_state = COLLECT;
        end
      end
      default: begin
        w_next_state = COLLECT;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_len      <= '0;
      r_overflow <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_clear) begin
        r_len <= '0;
      end else if (w_store) begin
        r_len <= r_len + LW'(1);
      end

      if (w_clear) begin
        r_overflow <= 1'b0;
      end else if (w_overflow_set) begin
        r_overflow <= 1'b1;
      end

      // A byte dropped in the same cycle as the acknowledge must still be
      // reported, so the set wins over the clear.
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (w_clear) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Buffer contents are never reset; the read mask below hides stale data.
  always_ff @(posedge i_Clk) begin
    if (w_store) begin
      r_buf[r_len[AW-1:0]] <= i_rx_data;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_rd_data <= 8'h00;
    end else if ({1'b0, i_rd_addr} < r_len) begin
      r_rd_data <= r_buf[i_rd_addr];
    end else begin
      r_rd_data <= 8'h00;
    end
  end

  assign o_rd_data    = r_rd_data;
  assign o_line_valid = (r_state == LINE_READY);
  assign o_line_len   = r_len;
  assign o_busy       = (r_state == COLLECT) && (r_len != '0);
  assign o_overflow   = r_overflow;
  assign o_overrun    = r_overrun;

endmodule
